// File: rtl/writeback_commit.sv
// Commit stage: turns executed results into GPR writes, PC loads, or buffered RAM stores.
// Stores drain in order through a FIFO and a two-state req/ack FSM.
module writeback_commit #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 32,
  parameter int REG_AW   = 4,
  parameter int SB_DEPTH = 4
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic                        in_store,
  input  logic                        in_branch,
  input  logic [REG_AW-1:0]           in_rd,
  input  logic [ADDR_W-1:0]           in_addr,
  input  logic [DATA_W-1:0]           in_result,
  output logic                        gpr_we,
  output logic [REG_AW-1:0]           gpr_waddr,
  output logic [DATA_W-1:0]           gpr_wdata,
  output logic                        pc_load,
  output logic [ADDR_W-1:0]           pc_value,
  output logic                        ram_req,
  output logic [ADDR_W-1:0]           ram_addr,
  output logic [DATA_W-1:0]           ram_wdata,
  input  logic                        ram_ack,
  output logic [$clog2(SB_DEPTH):0]   sb_count,
  output logic                        sb_empty
);

  localparam int PW = $clog2(SB_DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(SB_DEPTH);

  typedef enum logic {S_IDLE = 1'b0, S_REQ = 1'b1} ram_state_t;

  ram_state_t        state_r;
  logic [ADDR_W-1:0] sb_addr_r [SB_DEPTH];
  logic [DATA_W-1:0] sb_data_r [SB_DEPTH];
  logic [PW-1:0]     wr_ptr_r;
  logic [PW-1:0]     rd_ptr_r;
  logic [CW-1:0]     count_r;

  logic accept_s;
  logic is_gpr_s;
  logic is_branch_s;
  logic is_store_s;
  logic push_s;
  logic pop_s;

  assign in_ready = (count_r < DEPTH_C);
  assign accept_s = in_valid & in_ready;
  assign sb_count = count_r;
  assign sb_empty = (count_r == {CW{1'b0}}) & ~ram_req;
  assign push_s   = accept_s & is_store_s;
  // Only an ack against an outstanding request retires the head entry.
  assign pop_s    = (state_r == S_REQ) & ram_ack;

  // Decode the {store,branch} op class of the incoming result.
  always_comb begin
    is_gpr_s    = 1'b0;
    is_branch_s = 1'b0;
    is_store_s  = 1'b0;
    case ({in_store, in_branch})
      2'b01:   is_branch_s = 1'b1;
      2'b10:   is_store_s  = 1'b1;
      default: is_gpr_s    = 1'b1;
    endcase
  end

  // GPR write and PC load strobes; data outputs hold when the strobe is low.
  always_ff @(posedge clk) begin
    if (rst) begin
      gpr_we    <= 1'b0;
      gpr_waddr <= '0;
      gpr_wdata <= '0;
      pc_load   <= 1'b0;
      pc_value  <= '0;
    end else begin
      gpr_we  <= accept_s & is_gpr_s;
      pc_load <= accept_s & is_branch_s;
      if (accept_s & is_gpr_s) begin
        gpr_waddr <= in_rd;
        gpr_wdata <= in_result;
      end
      if (accept_s & is_branch_s) begin
        pc_value <= in_result[ADDR_W-1:0];
      end
    end
  end

  // Store-buffer payload storage; contents are don't-care until counted.
  always_ff @(posedge clk) begin
    if (push_s) begin
      sb_addr_r[wr_ptr_r] <= in_addr;
      sb_data_r[wr_ptr_r] <= in_result;
    end
  end

  // Store-buffer pointers and occupancy; pointers wrap naturally at SB_DEPTH.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      count_r  <= '0;
    end else begin
      if (push_s) begin
        wr_ptr_r <= wr_ptr_r + PW'(1);
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + PW'(1);
      end
      case ({push_s, pop_s})
        2'b10:   count_r <= count_r + CW'(1);
        2'b01:   count_r <= count_r - CW'(1);
        default: count_r <= count_r;
      endcase
    end
  end

  // RAM drain FSM: latch the head into the request registers and hold until ack.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r   <= S_IDLE;
      ram_req   <= 1'b0;
      ram_addr  <= '0;
      ram_wdata <= '0;
    end else begin
      case (state_r)
        S_IDLE: begin
          if (count_r != {CW{1'b0}}) begin
            ram_addr  <= sb_addr_r[rd_ptr_r];
            ram_wdata <= sb_data_r[rd_ptr_r];
            ram_req   <= 1'b1;
            state_r   <= S_REQ;
          end
        end
        S_REQ: begin
          if (ram_ack) begin
            ram_req <= 1'b0;
            state_r <= S_IDLE;
          end
        end
        default: begin
          ram_req <= 1'b0;
          state_r <= S_IDLE;
        end
      endcase
    end
  end

endmodule
